// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
//   sb_slot_t    : one scoreboard slot {valid, dst, wr, load}
//   SB_ADDR_W    : register-address width carried in a slot
//   FWD_REGFILE  : forward-select value meaning "read the register file"
//   REG_ZERO     : hardwired-zero register, never tracked
//   SLOT_BUBBLE  : an empty (invalid) slot
package pipe_pkg;

   localparam int SB_ADDR_W   = 5;
   localparam int FWD_REGFILE = 0;

   localparam logic [SB_ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic                 valid;
      logic [SB_ADDR_W-1:0] dst;
      logic                 wr;
      logic                 load;
   } sb_slot_t;

   localparam sb_slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-stage <-> hazard controller bundle.
// Handshake: id_valid offers the ID-stage instruction; issue is the
// acceptance. The instruction transfers into EX on a rising edge where
// id_valid & issue. stall/flush are advisory to the front end and never
// transfer anything themselves.
//   master : decode/control side (drives id_* and br_taken)
//   slave  : hazard controller (drives stall, flush, issue, fwd selects)
interface pipeline_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5,
   parameter int DEPTH      = 3,
   parameter int FWD_W      = $clog2(DEPTH + 1)
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_rs_used;
   logic                  id_rt_used;
   logic [REG_ADDR_W-1:0] id_dst;
   logic                  id_reg_write;
   logic                  id_mem_read;
   logic                  id_multi;
   logic                  br_taken;
   logic                  stall;
   logic                  flush;
   logic                  issue;
   logic [FWD_W-1:0]      fwd_a_sel;
   logic [FWD_W-1:0]      fwd_b_sel;

   modport master (
      output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dst,
             id_reg_write, id_mem_read, id_multi, br_taken,
      input  stall, flush, issue, fwd_a_sel, fwd_b_sel
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dst,
             id_reg_write, id_mem_read, id_multi, br_taken,
      output stall, flush, issue, fwd_a_sel, fwd_b_sel
   );
endinterface

// File: rtl/hazard_fwd_match.sv
// Youngest-match priority encoder for one ID source operand.
//   slots    : scoreboard, index 0 = EX (youngest) .. DEPTH-1 = WB
//   src/used : source register address and whether it is read
//   sel      : 0 = register file, k+1 = forward from slot k
//   load_use : youngest match is a load not yet forwardable
module hazard_fwd_match
   import pipe_pkg::*;
#(
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1,
   parameter int FWD_W    = $clog2(DEPTH + 1)
) (
   input  sb_slot_t             slots [DEPTH],
   input  logic [SB_ADDR_W-1:0] src,
   input  logic                 used,
   output logic [FWD_W-1:0]     sel,
   output logic                 load_use
);

   // Walk oldest to youngest so the youngest match overwrites.
   always_comb begin
      sel      = FWD_W'(FWD_REGFILE);
      load_use = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (used && (src != REG_ZERO) && slots[k].valid && slots[k].wr &&
             (slots[k].dst == src)) begin
            sel      = FWD_W'(k + 1);
            load_use = slots[k].load && (k < LOAD_LAT);
         end
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage MIPS pipeline.
// Tracks in-flight register writes in a DEPTH-slot shift register and
// produces forward selects, load-use / multi-cycle stalls and branch flush.
// Ports:
//   clk, rst_n   : clock (rising edge), async active-low reset
//   bus (slave)  : decode-stage bundle, see pipeline_hazard_ctrl_if
//   stall_count, flush_count : saturating event counters, present only
//                  when HAZARD_STATS_EN is defined
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int DEPTH      = 3,
   parameter int LOAD_LAT   = 1,
   parameter int MULTI_LAT  = 4,
   parameter int FWD_W      = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipeline_hazard_ctrl_if.slave bus
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]          stall_count,
   output logic [31:0]          flush_count
`endif
);

   localparam int CNT_W = (MULTI_LAT > 1) ? $clog2(MULTI_LAT) : 1;

   sb_slot_t              slots [DEPTH];
   logic [CNT_W-1:0]      busy_cnt;
   logic [REG_ADDR_W-1:0] rs_in, rt_in, dst_in;
   logic                  load_use_a, load_use_b;
   logic                  load_use, multi_busy;
   logic                  stall, flush, issue;
   sb_slot_t              new_slot;

   assign rs_in  = bus.id_rs;
   assign rt_in  = bus.id_rt;
   assign dst_in = bus.id_dst;

   hazard_fwd_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_W(FWD_W)) u_match_a (
      .slots    (slots),
      .src      (SB_ADDR_W'(rs_in)),
      .used     (bus.id_rs_used),
      .sel      (bus.fwd_a_sel),
      .load_use (load_use_a)
   );

   hazard_fwd_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_W(FWD_W)) u_match_b (
      .slots    (slots),
      .src      (SB_ADDR_W'(rt_in)),
      .used     (bus.id_rt_used),
      .sel      (bus.fwd_b_sel),
      .load_use (load_use_b)
   );

   assign load_use   = load_use_a | load_use_b;
   assign multi_busy = (busy_cnt != '0);

   // A taken branch squashes the ID instruction, so it overrides any stall.
   assign flush = bus.br_taken;
   assign stall = bus.id_valid & ~bus.br_taken & (load_use | multi_busy);
   assign issue = bus.id_valid & ~stall & ~bus.br_taken;

   assign bus.stall = stall;
   assign bus.flush = flush;
   assign bus.issue = issue;

   always_comb begin
      new_slot = SLOT_BUBBLE;
      if (issue) begin
         new_slot.valid = 1'b1;
         new_slot.dst   = SB_ADDR_W'(dst_in);
         new_slot.wr    = bus.id_reg_write;
         new_slot.load  = bus.id_mem_read;
      end
   end

   // Slots keep advancing while a multi-cycle op occupies EX: the op's write
   // is tracked from issue and bubbles follow it down the pipe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) slots[i] <= SLOT_BUBBLE;
      end else begin
         for (int i = DEPTH - 1; i >= 1; i--) slots[i] <= slots[i-1];
         slots[0] <= new_slot;
      end
   end

   // Not cleared by flush: the multi-cycle op is older than the branch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_cnt <= '0;
      end else if (issue && bus.id_multi) begin
         busy_cnt <= CNT_W'(MULTI_LAT - 1);
      end else if (busy_cnt != '0) begin
         busy_cnt <= busy_cnt - 1'b1;
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall && (stall_count != '1)) stall_count <= stall_count + 32'd1;
         if (flush && (flush_count != '1)) flush_count <= flush_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with default parameters
// (DEPTH=3, LOAD_LAT=1, MULTI_LAT=4). Each step drives one ID-stage
// instruction after the falling edge, queues the hand-derived expected
// {stall, flush, issue, fwd_a_sel, fwd_b_sel} and compares it against the
// combinational outputs shortly afterwards.
module tb_pipeline_hazard_ctrl;

   logic clk;
   logic rst_n;

   int total_cnt = 0;
   int bad_cnt   = 0;

   logic [6:0] exp_q[$];

   pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .DEPTH(3)) bus ();

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_count;
   logic [31:0] flush_count;
`endif

   pipeline_hazard_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave)
`ifdef HAZARD_STATS_EN
      ,
      .stall_count (stall_count),
      .flush_count (flush_count)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total_cnt++;
      if (obs !== exp_v) begin
         bad_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic drive_idle();
      bus.id_valid     = 1'b0;
      bus.id_rs        = '0;
      bus.id_rt        = '0;
      bus.id_rs_used   = 1'b0;
      bus.id_rt_used   = 1'b0;
      bus.id_dst       = '0;
      bus.id_reg_write = 1'b0;
      bus.id_mem_read  = 1'b0;
      bus.id_multi     = 1'b0;
      bus.br_taken     = 1'b0;
   endtask

   function automatic logic [6:0] observed();
      return {bus.stall, bus.flush, bus.issue, bus.fwd_a_sel, bus.fwd_b_sel};
   endfunction

   task automatic compare_next(input string tag);
      if (exp_q.size() == 0) begin
         check_eq({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         check_eq(tag, {25'd0, observed()}, {25'd0, exp_q.pop_front()});
      end
   endtask

   // driver: one ID instruction per cycle plus its expected outputs
   task automatic step(
      input int n,
      input logic v, input logic [4:0] rs, input logic [4:0] rt,
      input logic rsu, input logic rtu, input logic [4:0] dst,
      input logic wr, input logic ld, input logic mul, input logic br,
      input logic s, input logic f, input logic i,
      input logic [1:0] a, input logic [1:0] b
   );
      @(negedge clk);
      bus.id_valid     = v;
      bus.id_rs        = rs;
      bus.id_rt        = rt;
      bus.id_rs_used   = rsu;
      bus.id_rt_used   = rtu;
      bus.id_dst       = dst;
      bus.id_reg_write = wr;
      bus.id_mem_read  = ld;
      bus.id_multi     = mul;
      bus.br_taken     = br;
      exp_q.push_back({s, f, i, a, b});
      #1;
      compare_next($sformatf("c%0d", n));
   endtask

   initial begin
      rst_n = 1'b0;
      drive_idle();

      // reset state: issue follows id_valid, selects 0 despite nothing tracked
      step(0, 1, 3, 3, 1, 1, 3, 1, 0, 0, 0,   0, 0, 1, 0, 0);
      drive_idle();
      rst_n = 1'b1;

      // forwarding distance 1,2,3 then aged out
      step(1,  1, 1, 2, 1, 1, 3, 1, 0, 0, 0,  0, 0, 1, 0, 0);
      step(2,  1, 3, 0, 1, 1, 4, 1, 0, 0, 0,  0, 0, 1, 1, 0);
      step(3,  1, 3, 0, 1, 1, 5, 1, 0, 0, 0,  0, 0, 1, 2, 0);
      step(4,  1, 3, 0, 1, 1, 6, 1, 0, 0, 0,  0, 0, 1, 3, 0);
      step(5,  1, 3, 0, 1, 1, 3, 1, 0, 0, 0,  0, 0, 1, 0, 0);
      // two r3 in flight: youngest wins
      step(6,  1, 3, 0, 1, 1, 3, 1, 0, 0, 0,  0, 0, 1, 1, 0);
      step(7,  1, 9, 3, 1, 1, 0, 1, 0, 0, 0,  0, 0, 1, 0, 1);
      // r0 write in slot0 never forwards
      step(8,  1, 0, 3, 1, 1, 8, 1, 0, 0, 0,  0, 0, 1, 0, 2);
      // unused source ignores a live match in WB
      step(9,  1, 3, 8, 0, 1, 9, 1, 0, 0, 0,  0, 0, 1, 0, 1);
      // id_valid=0: no issue, selects still reflect the scoreboard
      step(10, 0, 9, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
      step(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      step(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      // load-use: one stall cycle then forward from slot1
      step(13, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0,  0, 0, 1, 0, 0);
      step(14, 1, 2, 5, 1, 1, 6, 1, 0, 0, 0,  1, 0, 0, 0, 1);
      step(15, 1, 2, 5, 1, 1, 6, 1, 0, 0, 0,  0, 0, 1, 0, 2);
      // branch with no valid ID instruction
      step(16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0);
      // multi-cycle op: 3 stall cycles, result tracked through WB
      step(17, 1, 1, 2, 1, 1, 10, 1, 0, 1, 0, 0, 0, 1, 0, 0);
      step(18, 1, 10, 0, 1, 1, 11, 1, 0, 0, 0, 1, 0, 0, 1, 0);
      step(19, 1, 10, 0, 1, 1, 11, 1, 0, 0, 0, 1, 0, 0, 2, 0);
      step(20, 1, 10, 0, 1, 1, 11, 1, 0, 0, 0, 1, 0, 0, 3, 0);
      step(21, 1, 10, 0, 1, 1, 11, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      // flush beats load-use, next cycle proceeds
      step(22, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0,  0, 0, 1, 0, 0);
      step(23, 1, 2, 5, 1, 1, 12, 1, 0, 0, 1, 0, 1, 0, 0, 1);
      step(24, 1, 2, 5, 1, 1, 12, 1, 0, 0, 0, 0, 0, 1, 0, 2);
      // flush beats multi_busy, but the counter keeps running
      step(25, 1, 1, 2, 1, 1, 13, 1, 0, 1, 0, 0, 0, 1, 0, 0);
      step(26, 1, 1, 0, 1, 1, 14, 1, 0, 0, 1, 0, 1, 0, 0, 0);
      step(27, 1, 1, 0, 1, 1, 14, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      step(28, 1, 1, 0, 1, 1, 14, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      step(29, 1, 1, 0, 1, 1, 14, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      // load in slot0 stalls a dependent, then reset mid-stall
      step(30, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0,  0, 0, 1, 0, 0);
      step(31, 1, 2, 5, 1, 1, 6, 1, 0, 0, 0,  1, 0, 0, 0, 1);
`ifdef HAZARD_STATS_EN
      check_eq("stall_count_run", stall_count, 32'd6);
      check_eq("flush_count_run", flush_count, 32'd3);
`endif
      rst_n = 1'b0;
      exp_q.push_back({1'b0, 1'b0, 1'b1, 2'd0, 2'd0});
      #1;
      compare_next("rst_mid");
`ifdef HAZARD_STATS_EN
      check_eq("stall_count_rst", stall_count, 32'd0);
      check_eq("flush_count_rst", flush_count, 32'd0);
`endif
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;
      // after release the dependent sees an empty scoreboard
      step(32, 1, 2, 5, 1, 1, 6, 1, 0, 0, 0,  0, 0, 1, 0, 0);

      if (exp_q.size() != 0) check_eq("queue_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the pipelined five-stage successor of the single-cycle MIPS core. It tracks in-flight register writes in a DEPTH-slot scoreboard shift register and selects forwarding sources for the ID-stage operands. It generates load-use and multi-cycle-op stalls and squashes on taken branches resolved in EX. It sits beside the datapath, fed by the decode stage and main control.

Parameters:
REG_ADDR_W, 5, register-address width; register 0 is hardwired zero and never tracked.
DEPTH, 3, slots between issue and writeback inclusive: slot0=EX, slot DEPTH-1=WB.
LOAD_LAT, 1, slots whose load result is not yet forwardable; a load in slot k with k < LOAD_LAT stalls a dependent.
MULTI_LAT, 4, EX occupancy in cycles of a multi-cycle op (mult/div); must be >= 1.
FWD_W, $clog2(DEPTH+1), derived width of the forward selects.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
id_valid  in  1  valid instruction in ID
id_rs  in  REG_ADDR_W  source A address
id_rt  in  REG_ADDR_W  source B address
id_rs_used  in  1  source A is read
id_rt_used  in  1  source B is read
id_dst  in  REG_ADDR_W  destination address
id_reg_write  in  1  instruction writes id_dst
id_mem_read  in  1  instruction is a load
id_multi  in  1  instruction is a multi-cycle op
br_taken  in  1  taken branch resolved in EX this cycle
stall  out  1  hold PC and IF/ID; insert bubble into EX
flush  out  1  squash IF/ID
issue  out  1  ID instruction enters EX this cycle
fwd_a_sel  out  FWD_W  0 = register file; k+1 = result of slot k
fwd_b_sel  out  FWD_W  as fwd_a_sel, for source B

Behaviour:
- Reset state is held while rst_n=0, independent of clk. All slots are invalid and busy_cnt=0. Under these conditions stall=0, flush=0, issue=id_valid, and both fwd selects are 0.
- Each slot holds {valid, dst, wr, load}.
- Match(k,r) is true when slot k is valid, wr=1, dst==r, and r!=0.
- Forward select for a source is (k+1), where k is the smallest (youngest) matching slot. It is 0 if the source is unused or no slot matches. This output is combinational.
- load_use is true when a used source's youngest match is a load slot with k < LOAD_LAT.
- multi_busy = (busy_cnt != 0).
- stall = id_valid & !br_taken & (load_use | multi_busy).
- flush = br_taken.
- issue = id_valid & !stall & !br_taken.
- On each rising edge:
  - slot[i] <= slot[i-1] for i >= 1.
  - slot[0] <= the ID instruction fields if issue, else a bubble (valid=0).
- Multi-cycle counter:
  - If issue & id_multi, busy_cnt <= MULTI_LAT-1.
  - Else if busy_cnt != 0, busy_cnt decrements.
  - The counter never wraps below 0.
- While busy_cnt != 0, slot advance still happens. Bubbles are inserted behind the multi-cycle op, and the op's write is tracked from issue.
- br_taken together with load_use or multi_busy: flush wins. stall=0, issue=0, and a bubble enters slot0.
- busy_cnt is not cleared by flush, because the multi-cycle op is older than the branch.
- Sources with address 0 always select 0 and never stall.
- A WB-slot match forwards the WB result (fwd = DEPTH). The register file's write-then-read timing is not relied on.
- id_valid=0: stall=0, issue=0, and a bubble is inserted.
- Reset mid-operation immediately invalidates all slots and the counter; the next edge after release is a normal cycle.

Optional Feature:
HAZARD_STATS_EN
- Defined: two extra outputs, stall_count[31:0] and flush_count[31:0].
  - Saturating counters incremented on each edge where stall=1 or flush=1 respectively.
  - Reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the slot struct typedef sb_slot_t {valid, dst, wr, load};
  - the FWD_REGFILE = 0 constant;
  - the REG_ZERO constant.
- Sub-module hazard_fwd_match, instantiated twice (A and B): combinational youngest-match priority encoder over the slot array, producing the select and a load_use flag.

Test Plan:
- Issue add r3; next cycle, ID add with rs=r3 -> fwd_a_sel=1, stall=0. One cycle later, with rs=r3 -> fwd_a_sel=2. Two cycles later -> fwd_a_sel=3.
- Issue lw r5; next cycle, ID uses rt=r5 -> stall=1 for exactly 1 cycle and a bubble enters slot0. Then issue=1 with fwd_b_sel=2.
- Write r0 in flight, then ID reads r0 -> fwd_a_sel=0, stall=0.
- Issue mult with MULTI_LAT=4, followed by a valid add -> stall=1 for 3 cycles, then issue=1.
- lw r5 followed by a dependent while br_taken=1 in the same cycle -> flush=1, stall=0, issue=0, slot0 bubble. Next cycle there is no stall.
- Assert rst_n=0 mid-stall with the load in slot0 -> stall drops immediately and all selects are 0. With HAZARD_STATS_EN, stall_count reads 0 after reset.
